cp0_regfile: RTL
================

// Module: cp0_regfile
// PURPOSE
//  CP0 register file and timer for the MIPS pipeline, in the WB stage directly downstream of the CP0 control decoder.
//  Consumes the 16-bit CP0 control bus, write/read selects and WB-stage PC/address.
//  Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14).
//  Produces the MFC0 read data, EPC for ERET redirect, and the interrupt request for the exception logic.
// PARAMETERS
//  STATUS_RESET  32'h0040_0000  Status reset value (BEV=1)
//  COUNT_DIV     2              clk cycles per Count increment (>=1)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  cp0_ctrl     in   16  {Compare_wden,Count_wden,cp0_choice,badaddr_wden,badaddr_choice,Status_wden,
//                         Status_EXL_choice,Status_EXL_wden,Cause_BD_wden,Cause_BD_choice,Cause_IP_10_wden,
//                         Cause_ExcCode_wden,Cause_ExcCode_choice[2:0],Epc_wden}  ([15]..[0])
//  cp0_dsel     in   1   1 = MTC0 write data valid (gates all MTC0-type writes)
//  cp0_osel     in   3   read select: 000 EPC,001 Status,010 Cause,011 BadVAddr,100 Count,101 Compare,11x -> 0
//  wdata        in   32  GPR rt value for MTC0
//  pc_w         in   32  PC of WB-stage instruction
//  data_addr_w  in   32  load/store effective address of WB-stage instruction
//  hw_int       in   6   external interrupt lines, level, active-high
//  rdata        out  32  combinational read of cp0_osel register
//  epc          out  32  EPC register
//  status       out  32  Status register
//  cause        out  32  Cause register
//  int_req      out  1   pending enabled interrupt
//  timer_int    out  1   Cause.TI
// BEHAVIOUR
//  - Reset (async, rst=1): Status=STATUS_RESET; Cause, EPC, BadVAddr, Count, Compare, divider = 0.
//    Outputs follow: int_req=0, timer_int=0, rdata = reset value of selected register.
//    Reset mid-operation aborts any pending write and clears the divider.
//  - Latency: all writes take effect at posedge; visible on rdata/outputs next cycle. Reads are combinational.
//  - Exception priority: when cp0_choice=1, all MTC0 writes (Status/Cause IP/Count/Compare/EPC-from-wdata) are
//    suppressed that cycle; only exception-path fields update.
//  - EPC (Epc_wden): cp0_choice ? (Cause_BD_choice ? pc_w-32'd4 : pc_w) : wdata (MTC0 needs cp0_dsel).
//  - BadVAddr (badaddr_wden): badaddr_choice ? data_addr_w : pc_w. Not software-writable.
//  - Status: writable bits IM[15:8], EXL[1], IE[0] via Status_wden&cp0_dsel; others hold reset value.
//    Status_EXL_wden: EXL <= Status_EXL_choice (1 on exception, 0 on ERET); overrides an MTC0 EXL write.
//  - Cause: BD[31] <= Cause_BD_choice on Cause_BD_wden.
//    ExcCode[6:2] on Cause_ExcCode_wden, mapped from choice:
//    001->4 AdEL, 010->5 AdES, 011->8 Sys, 100->9 Bp, 101->10 RI, 110->12 Ov, 111->0 Int, 000->hold.
//    IP[1:0] <= wdata[9:8] on Cause_IP_10_wden&cp0_dsel.
//    IP[6:2] = hw_int[4:0] sampled every cycle; IP[7] = hw_int[5] | TI; TI at [30]; other bits 0.
//  - Count: divider counts 0..COUNT_DIV-1; Count+1 (wraps FFFF_FFFF->0) when divider==COUNT_DIV-1.
//    Count MTC0 write wins over increment and clears the divider.
//  - TI: set at posedge when Count==Compare (registered values). Compare MTC0 write clears TI;
//    clear wins over a simultaneous set. TI holds until cleared or reset.
//  - int_req = IE & ~EXL & |(Cause[15:8] & Status[15:8]); combinational from registers, no hold-off.
// CONFIGURATION
//  CP0_TIMER_EN defined: Count, Compare, divider and TI implemented as above.
//  CP0_TIMER_EN undefined: no Count/Compare/divider flops; reads of Count/Compare return 0;
//    their writes ignored; TI=0, timer_int=0; IP[7]=hw_int[5].
// TESTING
//  1 Reset: rst=1 then 0 -> status=0x0040_0000, cause=0, epc=0, int_req=0; osel=001 -> rdata=0x0040_0000.
//  2 MTC0 Status: ctrl[10]=1, dsel=1, wdata=0xFFFF_FFFF -> status=0x0040_FF03 next cycle.
//  3 Sys in delay slot: ctrl[13,9,8,7,6,4,0]=1, ExcCode_choice=011, pc_w=0xBFC0_0104
//    -> epc=0xBFC0_0100, cause=0x8000_0020, status[1]=1.
//  4 AdEL load: ctrl[12,11]=1, ExcCode_choice=001, data_addr_w=0x1234_5671
//    -> osel=011 rdata=0x1234_5671, cause[6:2]=4.
//  5 Timer (EN): Compare=10, Count=0, Status=0x0000_8001 -> TI=1 after 20 clk, cause[30]=1, int_req=1;
//    MTC0 Compare -> TI=0, int_req=0.
//  6 ERET + collision: EXL_wden=1, choice=0 -> status[1]=0, epc unchanged;
//    exception with MTC0 Count same cycle -> Count not written.

Source files
------------

// File: rtl/cp0_regfile.sv
// CP0 register file and timer: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise they read as 0.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
  parameter int          COUNT_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cp0_ctrl,
  input  logic        cp0_dsel,
  input  logic [2:0]  cp0_osel,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_w,
  input  logic [31:0] data_addr_w,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic        int_req,
  output logic        timer_int
);

  logic       compare_wden;
  logic       count_wden;
  logic       cp0_choice;
  logic       badaddr_wden;
  logic       badaddr_choice;
  logic       status_wden;
  logic       exl_choice;
  logic       exl_wden;
  logic       bd_wden;
  logic       bd_choice;
  logic       ip10_wden;
  logic       exc_wden;
  logic [2:0] exc_choice;
  logic       epc_wden;

  assign compare_wden   = cp0_ctrl[15];
  assign count_wden     = cp0_ctrl[14];
  assign cp0_choice     = cp0_ctrl[13];
  assign badaddr_wden   = cp0_ctrl[12];
  assign badaddr_choice = cp0_ctrl[11];
  assign status_wden    = cp0_ctrl[10];
  assign exl_choice     = cp0_ctrl[9];
  assign exl_wden       = cp0_ctrl[8];
  assign bd_wden        = cp0_ctrl[7];
  assign bd_choice      = cp0_ctrl[6];
  assign ip10_wden      = cp0_ctrl[5];
  assign exc_wden       = cp0_ctrl[4];
  assign exc_choice     = cp0_ctrl[3:1];
  assign epc_wden       = cp0_ctrl[0];

  // An exception in flight blocks every software write this cycle
  logic mtc0;
  assign mtc0 = cp0_dsel & ~cp0_choice;

  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic        bd_q;
  logic [4:0]  exc_q;
  logic [1:0]  ip10_q;
  logic [5:0]  hw_q;
  logic        ti;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= '0;
    end else if (epc_wden) begin
      if (cp0_choice)
        epc_q <= bd_choice ? pc_w - 32'd4 : pc_w;
      else if (cp0_dsel)
        epc_q <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr_q <= '0;
    end else if (badaddr_wden) begin
      badvaddr_q <= badaddr_choice ? data_addr_w : pc_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im_q  <= STATUS_RESET[15:8];
      exl_q <= STATUS_RESET[1];
      ie_q  <= STATUS_RESET[0];
    end else begin
      if (status_wden & mtc0) begin
        im_q  <= wdata[15:8];
        exl_q <= wdata[1];
        ie_q  <= wdata[0];
      end
      if (exl_wden)
        exl_q <= exl_choice;
    end
  end

  logic [4:0] exc_next;
  logic       exc_vld;

  always_comb begin
    exc_next = exc_q;
    exc_vld  = 1'b1;
    case (exc_choice)
      3'b001:  exc_next = 5'd4;
      3'b010:  exc_next = 5'd5;
      3'b011:  exc_next = 5'd8;
      3'b100:  exc_next = 5'd9;
      3'b101:  exc_next = 5'd10;
      3'b110:  exc_next = 5'd12;
      3'b111:  exc_next = 5'd0;
      default: exc_vld  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bd_q   <= 1'b0;
      exc_q  <= '0;
      ip10_q <= '0;
      hw_q   <= '0;
    end else begin
      hw_q <= hw_int;
      if (bd_wden)
        bd_q <= bd_choice;
      if (exc_wden & exc_vld)
        exc_q <= exc_next;
      if (ip10_wden & mtc0)
        ip10_q <= wdata[9:8];
    end
  end

`ifdef CP0_TIMER_EN
  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [DW-1:0] div_q;
  logic          ti_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= '0;
    end else if (count_wden & mtc0) begin
      count_q <= wdata;
      div_q   <= '0;
    end else if (div_q == DIV_LAST) begin
      count_q <= count_q + 32'd1;
      div_q   <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // A Compare write acknowledges the timer and beats a same-cycle match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else if (compare_wden & mtc0) begin
      compare_q <= wdata;
      ti_q      <= 1'b0;
    end else if (count_q == compare_q) begin
      ti_q <= 1'b1;
    end
  end

  assign ti         = ti_q;
  assign count_rd   = count_q;
  assign compare_rd = compare_q;
`else
  logic unused_timer;
  assign unused_timer = &{1'b0, compare_wden, count_wden};
  assign ti           = 1'b0;
  assign count_rd     = '0;
  assign compare_rd   = '0;
`endif

  assign status = {STATUS_RESET[31:16], im_q, STATUS_RESET[7:2], exl_q, ie_q};
  assign cause  = {bd_q, ti, 14'b0, hw_q[5] | ti, hw_q[4:0],
                   ip10_q, 1'b0, exc_q, 2'b00};
  assign epc       = epc_q;
  assign timer_int = ti;
  assign int_req   = ie_q & ~exl_q & (|(cause[15:8] & status[15:8]));

  always_comb begin
    rdata = '0;
    case (cp0_osel)
      3'b000:  rdata = epc_q;
      3'b001:  rdata = status;
      3'b010:  rdata = cause;
      3'b011:  rdata = badvaddr_q;
      3'b100:  rdata = count_rd;
      3'b101:  rdata = compare_rd;
      default: rdata = '0;
    endcase
  end

endmodule
